serial_comparator: RTL and testbench
====================================

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit, a request to compare a against b.
REQ-005 The module SHALL have ports a and b, input, WIDTH bits each, unsigned operands sampled on an accepted start.
REQ-006 The module SHALL have port busy, output, 1 bit, high while a comparison is in progress.
REQ-007 The module SHALL have port done, output, 1 bit, a one-cycle pulse marking that the result is valid.
REQ-008 The module SHALL have ports eq, gt and lt, output, 1 bit each, the registered result of the last completed comparison (a==b, a>b, a<b).

Function
REQ-009 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-010 start high in IDLE or DONE at edge 0 SHALL load a and b into shift registers, set e_acc=1, g_acc=0 and bit count=WIDTH, and enter SHIFT.
REQ-011 In SHIFT, each edge SHALL pass MSB a1, MSB b1, e_acc and g_acc through one slice: e1 = e0 & ~(a1^b1), g1 = g0 | (e0 & a1 & ~b1).
REQ-012 On that same edge, the slice outputs SHALL be stored into e_acc/g_acc, both shift registers SHALL shift left by one, and the count SHALL decrement.
REQ-013 After the edge that processes the last (LSB) bit, which is edge WIDTH, the state SHALL be DONE.
REQ-014 On entry to DONE: eq=e_acc, gt=g_acc, lt=~e_acc&~g_acc; exactly one of eq/gt/lt high.
REQ-015 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-016 DONE SHALL last one cycle, then go to IDLE, or to SHIFT if start is high (back-to-back accept).
REQ-017 start while in SHIFT SHALL be ignored; operands and result remain those of the running operation.
REQ-018 eq/gt/lt SHALL hold their value from DONE until the next DONE, and SHALL not change during SHIFT.

Reset
REQ-019 reset high at any edge, including mid-SHIFT, SHALL force IDLE, busy=0, done=0, eq=gt=lt=0, shift registers=0, e_acc=1, g_acc=0 and count=0.
REQ-020 reset SHALL take priority over start on the same edge.

Configuration
REQ-021 With macro SERIAL_CMP_EARLY_EXIT_EN defined, an edge in SHIFT whose slice output has e1=0 SHALL move to DONE on that edge, skipping the remaining bits.
REQ-022 Without SERIAL_CMP_EARLY_EXIT_EN, SHIFT SHALL always take exactly WIDTH edges.
REQ-023 Result values SHALL be identical in both builds; only latency differs.

Structure
REQ-024 Package serial_cmp_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/DONE), the state encoding constants and the default WIDTH constant.
REQ-025 The bit step SHALL be a combinational sub-module bit_compare_slice (inputs a1, b1, e0, g0; outputs e1, g1), instantiated once.

Verification (WIDTH=8)
REQ-026 Scenario: reset, then start with a=0xA5, b=0xA5 -> done pulse after edge 8, eq=1 gt=0 lt=0, busy high after edges 1..7.
REQ-027 Scenario: a=0x80, b=0x7F -> gt=1; done after edge 1 with SERIAL_CMP_EARLY_EXIT_EN, after edge 8 without.
REQ-028 Scenario: a=0x00, b=0x01 -> lt=1, done after edge 8 in both builds.
REQ-029 Scenario: a=0x10, b=0x20 started, then start pulsed with a=0xFF, b=0x00 at edge 3 -> ignored, result lt=1.
REQ-030 Scenario: reset asserted at edge 4 mid-operation -> next cycle busy=0, done=0, eq=gt=lt=0; then start a=0x03, b=0x02 -> gt=1.
REQ-031 Scenario: start held high through DONE with new operands a=0x01, b=0x01 -> busy=1 the next cycle, second done reports eq=1.

Source files
------------

// File: rtl/serial_comparator_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package serial_cmp_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/serial_comparator_slice.sv
// One MSB-first comparison step: carries "equal so far" and "greater so far".
module bit_compare_slice (
  input  logic a1,
  input  logic b1,
  input  logic e0,
  input  logic g0,
  output logic e1,
  output logic g1
);

  assign e1 = e0 & ~(a1 ^ b1);
  assign g1 = g0 | (e0 & a1 & ~b1);

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial unsigned comparator, MSB first, one bit per clock.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN ends the scan at the first differing bit.
module serial_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             e_acc_r;
  logic             g_acc_r;
  logic [CW-1:0]    cnt_r;
  logic             e1_s;
  logic             g1_s;
  logic             load_s;
  logic             step_s;
  logic             finish_s;

  bit_compare_slice u_slice (
    .a1 (a_sh_r[WIDTH-1]),
    .b1 (b_sh_r[WIDTH-1]),
    .e0 (e_acc_r),
    .g0 (g_acc_r),
    .e1 (e1_s),
    .g1 (g1_s)
  );

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  // Once a bit differs the outcome is fixed, so the remaining bits are skipped.
  assign finish_s = (cnt_r == CW'(1)) | ~e1_s;
`else
  assign finish_s = (cnt_r == CW'(1));
`endif

  // Next-state and datapath control.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_next_s = SHIFT;
          load_s       = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        step_s = 1'b1;
        if (finish_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, operand shifters, accumulators and registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      eq      <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      e_acc_r <= 1'b1;
      g_acc_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      busy    <= (state_next_s == SHIFT);
      done    <= (state_next_s == DONE);
      if (load_s) begin
        a_sh_r  <= a;
        b_sh_r  <= b;
        e_acc_r <= 1'b1;
        g_acc_r <= 1'b0;
        cnt_r   <= CW'(WIDTH);
      end else if (step_s) begin
        a_sh_r  <= {a_sh_r[WIDTH-2:0], 1'b0};
        b_sh_r  <= {b_sh_r[WIDTH-2:0], 1'b0};
        e_acc_r <= e1_s;
        g_acc_r <= g1_s;
        cnt_r   <= cnt_r - CW'(1);
        if (finish_s) begin
          eq <= e1_s;
          gt <= g1_s;
          lt <= ~e1_s & ~g1_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench: directed scenarios plus random traffic against a
// latency/result model derived from plain integer comparison.
module tb_serial_comparator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, eq, gt, lt;

  int checks = 0;
  int errors = 0;

  serial_comparator #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Edges needed to decide a vs b.
  function automatic int lat_of(input logic [7:0] x, input logic [7:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = 7; i >= 0; i--) begin
      if (x[i] != y[i]) return 8 - i;
    end
`endif
    return 8;
  endfunction

  // Reference model: either idle or counting down the edges of a running compare.
  logic m_busy = 1'b0, m_done = 1'b0, m_eq = 1'b0, m_gt = 1'b0, m_lt = 1'b0;
  logic p_eq, p_gt, p_lt;
  int   m_rem = 0;
  bit   check_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0;
      m_eq = 1'b0; m_gt = 1'b0; m_lt = 1'b0;
      m_rem = 0;
      check_en = 1'b1;
    end else if (!m_busy) begin
      m_done = 1'b0;
      if (start) begin
        m_busy = 1'b1;
        m_rem  = lat_of(a, b);
        p_eq = (a == b); p_gt = (a > b); p_lt = (a < b);
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_eq = p_eq; m_gt = p_gt; m_lt = p_lt;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("eq",   {31'd0, eq},   {31'd0, m_eq});
      chk("gt",   {31'd0, gt},   {31'd0, m_gt});
      chk("lt",   {31'd0, lt},   {31'd0, m_lt});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until done is high; returns edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      cyc();
      n++;
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
  endtask

  // Accept one operation at the next edge and return the edges until done.
  task automatic run(input logic [7:0] x, input logic [7:0] y, output int n);
    start = 1'b1; a = x; b = y;
    cyc();
    start = 1'b0;
    wait_done(n);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    cyc(); cyc();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res",  {29'd0, eq, gt, lt}, 32'd0);
    reset = 1'b0;
    cyc();

    run(8'hA5, 8'hA5, n);
    chk("a5_lat", n, 32'd8);
    chk("a5_res", {29'd0, eq, gt, lt}, 32'b100);

    run(8'h80, 8'h7F, n);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    chk("gt_lat", n, 32'd1);
`else
    chk("gt_lat", n, 32'd8);
`endif
    chk("gt_res", {29'd0, eq, gt, lt}, 32'b010);

    run(8'h00, 8'h01, n);
    chk("lt_lat", n, 32'd8);
    chk("lt_res", {29'd0, eq, gt, lt}, 32'b001);
    cyc();

    // Start during SHIFT must be ignored.
    start = 1'b1; a = 8'h10; b = 8'h20;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    start = 1'b1; a = 8'hFF; b = 8'h00;
    cyc();
    start = 1'b0;
    wait_done(n);
    chk("ign_res", {29'd0, eq, gt, lt}, 32'b001);
    cyc();

    // Reset mid-operation.
    start = 1'b1; a = 8'h55; b = 8'h55;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    reset = 1'b1;
    cyc();
    chk("mid_rst", {27'd0, busy, done, eq, gt, lt}, 32'd0);
    reset = 1'b0;
    run(8'h03, 8'h02, n);
    chk("after_rst", {29'd0, eq, gt, lt}, 32'b010);

    // Back-to-back accept with start held through DONE.
    start = 1'b1; a = 8'h40; b = 8'h41;
    cyc();
    wait_done(n);
    a = 8'h01; b = 8'h01;
    cyc();
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done(n);
    chk("b2b_res", {29'd0, eq, gt, lt}, 32'b100);
    cyc();

    // Random traffic, including occasional resets and near-equal operands.
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 2) == 0);
      a = 8'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (8'd1 << $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
      cyc();
    end
    reset = 1'b0; start = 1'b0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
